// File: rtl/rob_alloc_commit_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rob_pkg                                                           |
// | Brief  : Shared types and sizing for the ROB allocate/commit sequencer.    |
// |          rob_entry_t  - per-entry bookkeeping {valid,done,exc,writes_rd,rd}|
// |          rob_state_e  - sequencer state {RUN, FLUSH}                       |
// |          ROB_ENTRIES  - number of ROB slots (2**ROB_ENTRY_WIDTH)           |
// |          Widths default from `ARCH_REG_INDEX_SIZE / `ROB_ENTRY_WIDTH.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+

`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif

`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif

package rob_pkg;

    localparam int DEF_ARCH_REG_INDEX_SIZE = `ARCH_REG_INDEX_SIZE;
    localparam int DEF_ROB_ENTRY_WIDTH     = `ROB_ENTRY_WIDTH;
    localparam int ROB_ENTRIES             = 2 ** DEF_ROB_ENTRY_WIDTH;

    // The entry record is sized from the package widths; the controller's
    // parameters must be left at (or set equal to) these values.
    typedef struct packed {
        logic                               valid;
        logic                               done;
        logic                               exc;
        logic                               writes_rd;
        logic [DEF_ARCH_REG_INDEX_SIZE-1:0] rd;
    } rob_entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_state_e;

endpackage

`default_nettype wire

// File: rtl/rob_alloc_commit_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rob_alloc_commit_ctrl_if                                          |
// | Brief  : Bundle of dispatch, rename, writeback, commit and status signals  |
// |          of the ROB sequencer.                                             |
// |          master - the sequencer side (drives ready/rename/commit/flush)    |
// |          slave  - the dispatch/execute/table side                          |
// |          ROB_PERF_CNT_EN adds perf_commits / perf_full_stalls.             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+

interface rob_alloc_commit_ctrl_if #(
    parameter int ARCH_REG_INDEX_SIZE = 5,
    parameter int ROB_ENTRY_WIDTH     = 3
);
    // dispatch
    logic                           disp_valid;
    logic                           disp_ready;
    logic                           disp_writes_rd;
    logic [ARCH_REG_INDEX_SIZE-1:0] disp_rd;
    logic [ROB_ENTRY_WIDTH-1:0]     disp_rob_id;
    // rename port of the table
    logic                           ren_renaming_reg;
    logic [ARCH_REG_INDEX_SIZE-1:0] ren_rd;
    logic [ROB_ENTRY_WIDTH-1:0]     ren_rob_id;
    // writeback
    logic                           wb_valid;
    logic [ROB_ENTRY_WIDTH-1:0]     wb_rob_id;
    logic                           wb_exception;
    // commit port of the table
    logic                           commit;
    logic [ARCH_REG_INDEX_SIZE-1:0] commit_rd;
    logic [ROB_ENTRY_WIDTH-1:0]     commit_rob_id;
    logic                           commit_exception;
    logic                           flush;
    // status
    logic [ROB_ENTRY_WIDTH:0]       rob_count;
    logic                           rob_empty;
    logic                           rob_full;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]                    perf_commits;
    logic [31:0]                    perf_full_stalls;
`endif

`ifdef ROB_PERF_CNT_EN
    modport master (
        input  disp_valid, disp_writes_rd, disp_rd, wb_valid, wb_rob_id, wb_exception,
        output disp_ready, disp_rob_id, ren_renaming_reg, ren_rd, ren_rob_id,
               commit, commit_rd, commit_rob_id, commit_exception, flush,
               rob_count, rob_empty, rob_full, perf_commits, perf_full_stalls
    );
    modport slave (
        output disp_valid, disp_writes_rd, disp_rd, wb_valid, wb_rob_id, wb_exception,
        input  disp_ready, disp_rob_id, ren_renaming_reg, ren_rd, ren_rob_id,
               commit, commit_rd, commit_rob_id, commit_exception, flush,
               rob_count, rob_empty, rob_full, perf_commits, perf_full_stalls
    );
`else
    modport master (
        input  disp_valid, disp_writes_rd, disp_rd, wb_valid, wb_rob_id, wb_exception,
        output disp_ready, disp_rob_id, ren_renaming_reg, ren_rd, ren_rob_id,
               commit, commit_rd, commit_rob_id, commit_exception, flush,
               rob_count, rob_empty, rob_full
    );
    modport slave (
        output disp_valid, disp_writes_rd, disp_rd, wb_valid, wb_rob_id, wb_exception,
        input  disp_ready, disp_rob_id, ren_renaming_reg, ren_rd, ren_rob_id,
               commit, commit_rd, commit_rob_id, commit_exception, flush,
               rob_count, rob_empty, rob_full
    );
`endif

endinterface

`default_nettype wire

// File: rtl/rob_alloc_commit_ctrl_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rob_ptr                                                           |
// | Brief  : Wrapping WIDTH-bit ROB pointer. clear has priority over inc.      |
// |          Ports: clk, reset (async, active-high), inc, clear, ptr.          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+

module rob_ptr #(
    parameter int WIDTH = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             inc,
    input  wire logic             clear,
    output logic [WIDTH-1:0]      ptr
);

    // Natural binary wrap gives the modulo-ROB_ENTRIES behaviour for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rob_alloc_commit_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rob_alloc_commit_ctrl                                             |
// | Brief  : ROB sequencer between dispatch and the rename table. Allocates    |
// |          ids in order at the tail, records completion from writeback, and  |
// |          retires the head in program order. An excepting head produces one |
// |          commit_exception cycle followed by a one-cycle flush that clears  |
// |          all in-flight state.                                              |
// |          Ports: clk, reset (async, active-high), bus (master modport):     |
// |            dispatch  disp_valid/ready/writes_rd/rd/rob_id                  |
// |            rename    ren_renaming_reg/rd/rob_id                            |
// |            writeback wb_valid/rob_id/exception                             |
// |            commit    commit/commit_rd/commit_rob_id/commit_exception/flush |
// |            status    rob_count/rob_empty/rob_full                          |
// |          ROB_PERF_CNT_EN: adds saturating perf_commits, perf_full_stalls.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+

module rob_alloc_commit_ctrl
    import rob_pkg::*;
#(
    parameter int ARCH_REG_INDEX_SIZE = DEF_ARCH_REG_INDEX_SIZE,
    parameter int ROB_ENTRY_WIDTH     = DEF_ROB_ENTRY_WIDTH
) (
    input  wire logic                clk,
    input  wire logic                reset,
    rob_alloc_commit_ctrl_if.master  bus
);

    localparam int                     ENTRIES    = 2 ** ROB_ENTRY_WIDTH;
    localparam logic [ROB_ENTRY_WIDTH:0] FULL_COUNT = ENTRIES[ROB_ENTRY_WIDTH:0];
    localparam logic [ROB_ENTRY_WIDTH:0] COUNT_ONE  = {{ROB_ENTRY_WIDTH{1'b0}}, 1'b1};

    rob_entry_t                   entries [ENTRIES];
    rob_entry_t                   head_entry;
    rob_state_e                   state;
    rob_state_e                   state_next;

    logic [ROB_ENTRY_WIDTH-1:0]   head;
    logic [ROB_ENTRY_WIDTH-1:0]   tail;
    logic [ROB_ENTRY_WIDTH:0]     count;

    logic                         full;
    logic                         empty;
    logic                         ready;
    logic                         transfer;
    logic                         do_commit;
    logic                         head_exc;
    logic                         flushing;

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    rob_ptr #(.WIDTH(ROB_ENTRY_WIDTH)) u_head_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (do_commit),
        .clear (flushing),
        .ptr   (head)
    );

    rob_ptr #(.WIDTH(ROB_ENTRY_WIDTH)) u_tail_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (transfer),
        .clear (flushing),
        .ptr   (tail)
    );

    assign head_entry = entries[head];
    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Commit/exception decisions come only from the registered head entry,
    // so a writeback can retire at the earliest on the following cycle.
    // Ready is withheld when full even if the head retires this cycle: the
    // freed slot is only reusable on the next cycle.
    always_comb begin
        state_next = state;
        do_commit  = 1'b0;
        head_exc   = 1'b0;
        flushing   = 1'b0;
        ready      = 1'b0;
        case (state)
            RUN: begin
                head_exc  = head_entry.valid & head_entry.done & head_entry.exc;
                do_commit = head_entry.valid & head_entry.done & ~head_entry.exc;
                ready     = ~full & ~head_exc;
                if (head_exc) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                flushing   = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign transfer = bus.disp_valid & ready;

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    // Writeback validity is judged on the registered valid bit, so a
    // writeback aimed at the slot being allocated this cycle is dropped and
    // the allocation wins. Commit and dispatch never target the same slot:
    // equal pointers mean empty (no commit) or full (no dispatch).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else if (flushing) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (bus.wb_valid && entries[bus.wb_rob_id].valid) begin
                entries[bus.wb_rob_id].done <= 1'b1;
                entries[bus.wb_rob_id].exc  <= bus.wb_exception;
            end
            if (do_commit) begin
                entries[head].valid <= 1'b0;
            end
            if (transfer) begin
                entries[tail] <= '{valid:     1'b1,
                                   done:      1'b0,
                                   exc:       1'b0,
                                   writes_rd: bus.disp_writes_rd,
                                   rd:        bus.disp_rd};
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flushing) begin
            count <= '0;
        end else begin
            case ({transfer, do_commit})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional performance counters (saturating, survive flush)
    // ------------------------------------------------------------------
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commits;
    logic [31:0] perf_full_stalls;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_commits     <= '0;
            perf_full_stalls <= '0;
        end else begin
            if (do_commit && (perf_commits != '1)) begin
                perf_commits <= perf_commits + 32'd1;
            end
            if (bus.disp_valid && full && (perf_full_stalls != '1)) begin
                perf_full_stalls <= perf_full_stalls + 32'd1;
            end
        end
    end

    assign bus.perf_commits     = perf_commits;
    assign bus.perf_full_stalls = perf_full_stalls;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.disp_ready       = ready;
    assign bus.disp_rob_id      = tail;
    // r0 is hard-wired, so writes to it never create a rename.
    assign bus.ren_renaming_reg = transfer & bus.disp_writes_rd & (bus.disp_rd != '0);
    assign bus.ren_rd           = bus.disp_rd;
    assign bus.ren_rob_id       = tail;
    assign bus.commit           = do_commit;
    assign bus.commit_rd        = head_entry.writes_rd ? head_entry.rd : '0;
    assign bus.commit_rob_id    = head;
    assign bus.commit_exception = head_exc;
    assign bus.flush            = flushing;
    assign bus.rob_count        = count;
    assign bus.rob_empty        = empty;
    assign bus.rob_full         = full;

endmodule

`default_nettype wire
